task_dispatch_ctrl: RTL and testbench

TASK_DISPATCH_CTRL -- requirements
Module: task_dispatch_ctrl

---
 rtl/task_dispatch_ctrl.sv | 116 +++++++++++
 tb/tb_task_dispatch_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatch_ctrl.sv
// task_dispatch_ctrl: hands task descriptors to idle cores and times each run; define RR_SELECT_EN for round-robin core selection (default lowest-index idle core).
module task_dispatch_ctrl #(
  parameter int NUM_PROC = 3,
  parameter int ID_W     = 8,
  parameter int FLV_W    = 3,
  parameter int CYC_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      task_valid,
  output logic                      task_ready,
  input  logic                      task_last,
  input  logic [ID_W-1:0]           task_id,
  input  logic [FLV_W-1:0]          task_freq,
  input  logic [CYC_W-1:0]          task_cycles,
  output logic [NUM_PROC-1:0]       core_start,
  output logic [NUM_PROC*ID_W-1:0]  core_task,
  output logic [NUM_PROC*FLV_W-1:0] core_freq,
  output logic [NUM_PROC-1:0]       core_busy,
  output logic [NUM_PROC-1:0]       core_done,
  output logic                      sched_done,
  output logic [31:0]               makespan,
  output logic [ID_W-1:0]           tasks_dispatched
);
  localparam int IDX_W = NUM_PROC > 1 ? $clog2(NUM_PROC) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_PROC-1:0]             busy_q, start_q, done_q;
  logic [NUM_PROC-1:0][CYC_W-1:0]  cnt_q;
  logic [NUM_PROC-1:0][ID_W-1:0]   task_q;
  logic [NUM_PROC-1:0][FLV_W-1:0]  freq_q;
  logic [31:0]                     makespan_q;
  logic [ID_W-1:0]                 disp_q;
  logic [IDX_W-1:0]                sel, base;
  logic                            hs, run_act;
  int                              idx;
`ifdef RR_SELECT_EN
  logic [IDX_W-1:0] ptr_q;
  assign base = ptr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else if (hs) ptr_q <= (sel == IDX_W'(NUM_PROC-1)) ? '0 : sel + 1'b1;
`else
  assign base = '0;
`endif
  // Scan downward so the idle core nearest to base is the last one written.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int i = NUM_PROC-1; i >= 0; i--) begin
      idx = int'(base) + i;
      if (idx >= NUM_PROC) idx = idx - NUM_PROC;
      if (!busy_q[idx]) sel = IDX_W'(idx);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start ? RUN : IDLE;
      RUN:   state_d = (hs && task_last) ? DRAIN : RUN;
      DRAIN: state_d = (busy_q == '0) ? DONE : DRAIN;
      DONE:  state_d = IDLE;
    endcase
  end
  always_comb begin
    task_ready = (state_q == RUN) && !(&busy_q);
    sched_done = (state_q == DONE);
    run_act    = (state_q == RUN) || (state_q == DRAIN);
  end
  assign hs = task_valid && task_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy_q  <= '0;
      start_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      task_q  <= '0;
      freq_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_PROC; c++) begin
        start_q[c] <= hs && (sel == IDX_W'(c));
        done_q[c]  <= busy_q[c] && (cnt_q[c] == CYC_W'(1));
        if (hs && (sel == IDX_W'(c))) begin
          cnt_q[c]  <= (task_cycles == '0) ? CYC_W'(1) : task_cycles;
          busy_q[c] <= 1'b1;
          task_q[c] <= task_id;
          freq_q[c] <= task_freq;
        end else if (busy_q[c]) begin
          cnt_q[c]  <= cnt_q[c] - 1'b1;
          busy_q[c] <= (cnt_q[c] != CYC_W'(1));
        end
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      makespan_q <= '0;
      disp_q     <= '0;
    end else if (state_q == IDLE && start) begin
      makespan_q <= '0;
      disp_q     <= '0;
    end else begin
      if (run_act && makespan_q != '1) makespan_q <= makespan_q + 1'b1;
      if (hs) disp_q <= disp_q + 1'b1;
    end
  assign core_start       = start_q;
  assign core_busy        = busy_q;
  assign core_done        = done_q;
  assign core_task        = task_q;
  assign core_freq        = freq_q;
  assign makespan         = makespan_q;
  assign tasks_dispatched = disp_q;
endmodule

// File: tb/tb_task_dispatch_ctrl.sv
// tb_task_dispatch_ctrl: directed scenarios with a launch scoreboard for task_dispatch_ctrl.
module tb_task_dispatch_ctrl;
  localparam int NP = 3, IW = 8, FW = 3, CW = 16;
  logic clk = 0, reset = 1, start = 0, task_valid = 0, task_last = 0;
  logic [IW-1:0] task_id = '0;
  logic [FW-1:0] task_freq = '0;
  logic [CW-1:0] task_cycles = '0;
  logic task_ready, sched_done;
  logic [NP-1:0] core_start, core_busy, core_done;
  logic [NP*IW-1:0] core_task;
  logic [NP*FW-1:0] core_freq;
  logic [31:0] makespan;
  logic [IW-1:0] tasks_dispatched;
  typedef struct {int core; int id; int freq; int cyc;} exp_t;
  exp_t sb[$];
  int done_log[$];
  int busy_cnt[NP];
  int exp_cyc[NP];
  int nchk = 0, nerr = 0;
  bit rr;

  task_dispatch_ctrl #(.NUM_PROC(NP), .ID_W(IW), .FLV_W(FW), .CYC_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .task_valid(task_valid), .task_ready(task_ready),
    .task_last(task_last), .task_id(task_id), .task_freq(task_freq), .task_cycles(task_cycles),
    .core_start(core_start), .core_task(core_task), .core_freq(core_freq), .core_busy(core_busy),
    .core_done(core_done), .sched_done(sched_done), .makespan(makespan),
    .tasks_dispatched(tasks_dispatched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < NP; c++) busy_cnt[c] = 0;
    end else begin
      if (core_start != '0) chk("start_onehot", $countones(core_start), 1);
      for (int c = 0; c < NP; c++) begin
        if (core_start[c]) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("core_sel", c, e.core);
            chk("core_task", 32'(core_task[c*IW +: IW]), e.id);
            chk("core_freq", 32'(core_freq[c*FW +: FW]), e.freq);
            exp_cyc[c] = (e.cyc == 0) ? 1 : e.cyc;
            busy_cnt[c] = 0;
          end
        end
        if (core_busy[c]) busy_cnt[c]++;
        if (core_done[c]) begin
          chk("busy_len", busy_cnt[c], exp_cyc[c]);
          done_log.push_back(c);
        end
      end
    end
  end

  task automatic send(input int id, input int freq, input int cyc, input logic last, input int core);
    int n = 0;
    task_valid = 1; task_id = IW'(id); task_freq = FW'(freq); task_cycles = CW'(cyc); task_last = last;
    while (!task_ready && n < 100) begin @(negedge clk); n++; end
    if (!task_ready) chk("ready_timeout", 0, 1);
    else sb.push_back('{core, id, freq, cyc});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic idle_bus();
    task_valid = 0; task_last = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!sched_done && n < 200) begin @(negedge clk); n++; end
    chk("sched_done_seen", 32'(sched_done), 1);
  endtask

  task automatic wait_idle_cores();
    int n = 0;
    while (core_busy != '0 && n < 200) begin @(negedge clk); n++; end
    chk("cores_idle", 32'(core_busy), 0);
  endtask

  initial begin
`ifdef RR_SELECT_EN
    rr = 1;
`else
    rr = 0;
`endif
    #12;
    chk("rst_busy", 32'(core_busy), 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_done", 32'(core_done), 0);
    chk("rst_task", 32'(core_task), 0);
    chk("rst_freq", 32'(core_freq), 0);
    chk("rst_makespan", makespan, 0);
    chk("rst_disp", 32'(tasks_dispatched), 0);
    chk("rst_sched_done", 32'(sched_done), 0);
    @(negedge clk);
    reset = 0;
    // valid without start: never ready, nothing dispatched
    task_valid = 1; task_id = 8'h55; task_cycles = 16'd4;
    for (int k = 0; k < 5; k++) begin
      chk("nostart_ready", 32'(task_ready), 0);
      @(negedge clk);
    end
    chk("nostart_disp", 32'(tasks_dispatched), 0);
    idle_bus();
    @(negedge clk);
    // three back-to-back tasks 5/3/4
    pulse_start();
    send(1, 2, 5, 0, 0);
    send(2, 3, 3, 0, 1);
    send(3, 4, 4, 1, 2);
    idle_bus();
    wait_done();
    chk("s1_makespan", makespan, 8);
    chk("s1_disp", 32'(tasks_dispatched), 3);
    chk("s1_ndone", done_log.size(), 3);
    if (done_log.size() == 3) begin
      chk("s1_done0", done_log[0], 1);
      chk("s1_done1", done_log[1], 0);
      chk("s1_done2", done_log[2], 2);
    end
    @(negedge clk);
    chk("s1_done_pulse", 32'(sched_done), 0);
    chk("s1_makespan_hold", makespan, 8);
    chk("s1_idle_ready", 32'(task_ready), 0);
    done_log.delete();
    // fourth task while all cores busy
    pulse_start();
    chk("s2_clear_makespan", makespan, 0);
    send(4, 1, 6, 0, 0);
    send(5, 5, 3, 0, 1);
    send(6, 6, 8, 0, 2);
    idle_bus();
    chk("s2_ready_full", 32'(task_ready), 0);
    for (int n = 0; n < 50 && core_done == '0; n++) begin
      @(negedge clk);
      if (core_done == '0) chk("s2_ready_wait", 32'(task_ready), 0);
    end
    chk("s2_first_done", 32'(core_done), 32'b010);
    chk("s2_ready_freed", 32'(task_ready), 1);
    send(7, 7, 2, 1, 1);
    idle_bus();
    wait_done();
    chk("s2_disp", 32'(tasks_dispatched), 4);
    chk("s2_makespan", makespan, 12);
    @(negedge clk);
    // zero-cycle task occupies its core for one cycle
    pulse_start();
    send(8, 3, 0, 1, rr ? 2 : 0);
    idle_bus();
    wait_done();
    chk("s3_makespan", makespan, 3);
    chk("s3_disp", 32'(tasks_dispatched), 1);
    @(negedge clk);
    // reset with two cores busy
    done_log.delete();
    pulse_start();
    send(9, 1, 20, 0, 0);
    send(10, 2, 20, 0, 1);
    idle_bus();
    chk("s5_busy_before", 32'(core_busy), 32'b011);
    #1 reset = 1;
    #1;
    chk("s5_busy", 32'(core_busy), 0);
    chk("s5_start", 32'(core_start), 0);
    chk("s5_task", 32'(core_task), 0);
    chk("s5_freq", 32'(core_freq), 0);
    chk("s5_makespan", makespan, 0);
    chk("s5_disp", 32'(tasks_dispatched), 0);
    chk("s5_ready", 32'(task_ready), 0);
    chk("s5_sched_done", 32'(sched_done), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("s5_no_done", 32'(core_done), 0);
    end
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s5_post_done", 32'(core_done), 0);
      chk("s5_post_ready", 32'(task_ready), 0);
    end
    chk("s5_no_done_log", done_log.size(), 0);
    // sequential single tasks, each finishing before the next
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      send(20 + k, k, 2, k == 3, rr ? k % NP : 0);
      idle_bus();
      if (k < 3) wait_idle_cores();
    end
    wait_done();
    chk("s6_disp", 32'(tasks_dispatched), 4);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
